// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size codes, FSM state encoding and default memory size.
package lsu_pkg;

  localparam int LSU_ADDR_LIMIT = 256;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Load extraction/extension and store merge for 8-byte memory words.
// in: raw dword, size, unsigned, wdata; out: load_val, merged.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);

  logic sb;
  logic sh;
  logic sw;

  assign sb = ~uns & raw[7];
  assign sh = ~uns & raw[15];
  assign sw = ~uns & raw[31];

  always_comb begin
    load_val = raw;
    merged   = wdata;
    unique case (size)
      SZ_B: begin
        load_val = {{(XLEN-8){sb}}, raw[7:0]};
        merged   = {raw[XLEN-1:8], wdata[7:0]};
      end
      SZ_H: begin
        load_val = {{(XLEN-16){sh}}, raw[15:0]};
        merged   = {raw[XLEN-1:16], wdata[15:0]};
      end
      SZ_W: begin
        load_val = {{(XLEN-32){sw}}, raw[31:0]};
        merged   = {raw[XLEN-1:32], wdata[31:0]};
      end
      SZ_D: begin
        load_val = raw;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator onto a full-dword memory.
// Ports: req_* from execute, resp_* back, mem_* to data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_LIMIT = LSU_ADDR_LIMIT,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [XLEN-1:0] MAX_BASE =
    XLEN'(ADDR_LIMIT - 8);

  lsu_state_e state_q;
  lsu_state_e state_d;

  logic            write_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] merged_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic            accept;
  logic            bad_addr;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;

  assign accept   = (state_q == IDLE) & req_valid;
  assign bad_addr = req_addr > MAX_BASE;

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .raw      (mem_rdata),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (bad_addr)
            state_d = RESP;
          else if (req_write && req_size == SZ_D)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (bad_addr) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
      end
      if (state_q == RD) begin
        if (write_q) begin
          merged_q <= merged;
        end else begin
          rdata_q <= load_val;
          fault_q <= 1'b0;
        end
      end
      if (state_q == WR) begin
        rdata_q <= '0;
        fault_q <= 1'b0;
      end
    end
  end

  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign mem_read   = state_q == RD;
  assign mem_write  = state_q == WR;
  assign mem_addr   = addr_q;
  assign mem_wdata  = (size_q == SZ_D) ? wdata_q : merged_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit.
// Byte-array memory plus a byte-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  logic [7:0] mem [0:255];
  logic [7:0] rmem [0:255];

  int n_chk;
  int n_err;

  load_store_unit #(
    .ADDR_LIMIT (256),
    .XLEN       (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [63:0] a;
    a = '0;
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      a = mem_addr + 64'(i);
      if (a < 64'd256)
        mem_rdata[8*i +: 8] = mem[a[7:0]];
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        if (mem_addr + 64'(i) < 64'd256)
          mem[8'(mem_addr + 64'(i))] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(
    input logic [63:0] a, input logic [1:0] sz, input logic u);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (64'(rmem[8'(a + 64'(i))]) << (8 * i));
    if (!u && n < 8 && v[8*n-1])
      v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a,
                           input logic [1:0] sz,
                           input logic [63:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++)
      rmem[8'(a + 64'(i))] = wd[8*i +: 8];
  endtask

  function automatic logic [63:0] mem_dw(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v[8*i +: 8] = mem[a + i];
    return v;
  endfunction

  task automatic do_req(input logic w,
                        input logic [1:0] sz,
                        input logic u,
                        input logic [63:0] a,
                        input logic [63:0] wd,
                        output logic [63:0] got);
    logic flt;
    logic acc;
    logic done;
    logic [63:0] exp;
    int lat;
    int rd;
    int wr;
    int exp_lat;
    flt = a > 64'd248;
    exp = (!w && !flt) ? ref_load(a, sz, u) : 64'd0;
    exp_lat = flt ? 1 : ((!w || sz == 2'd3) ? 2 : 3);
    got = '0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = req_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 req_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    rd = 0;
    wr = 0;
    lat = 0;
    done = 1'b0;
    for (int n = 1; n <= 8 && !done; n++) begin
      @(negedge clk);
      rd += int'(mem_read);
      wr += int'(mem_write);
      if (resp_valid) begin
        done = 1'b1;
        lat = n;
        got = resp_rdata;
        chk("resp_fault", 64'(resp_fault), 64'(flt));
        chk("ready_in_resp", 64'(req_ready), 64'd0);
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_rdata", got, exp);
    chk("rd_cycles", 64'(rd),
        64'((flt || (w && sz == 2'd3)) ? 0 : 1));
    chk("wr_cycles", 64'(wr), 64'((!flt && w) ? 1 : 0));
    if (w && !flt) begin
      ref_store(a, sz, wd);
      chk("mem_after_store", mem_dw(int'(a[7:0])),
          ref_load(a, 2'd3, 1'b0));
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] ra;
    logic rw;
    logic [1:0] rs;
    int bad;
    int seen;
    n_chk = 0;
    n_err = 0;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 48; i++) mem[i] = 8'h00;
    mem[0]  = 8'd5;
    mem[8]  = 8'd10;
    mem[16] = 8'd1;
    mem[40] = 8'd12;
    for (int i = 0; i < 256; i++) rmem[i] = mem[i];

    #3;
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fault", 64'(resp_fault), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_ready", 64'(req_ready), 64'd1);

    do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, r);
    chk("ld8", r, 64'h000000000000000A);
    do_req(1'b1, 2'd0, 1'b0, 64'd16, 64'hFF, r);
    chk("sb16_dw2", mem_dw(16), 64'h00000000000000FF);
    do_req(1'b0, 2'd0, 1'b0, 64'd16, 64'd0, r);
    chk("lb16", r, 64'hFFFFFFFFFFFFFFFF);
    do_req(1'b0, 2'd0, 1'b1, 64'd16, 64'd0, r);
    chk("lbu16", r, 64'h00000000000000FF);
    do_req(1'b1, 2'd1, 1'b0, 64'd2, 64'h1234ABCD, r);
    chk("sh2_dw0", mem_dw(0), 64'h00000000ABCD0005);
    do_req(1'b0, 2'd2, 1'b0, 64'd0, 64'd0, r);
    chk("lw0", r, 64'hFFFFFFFFABCD0005);
    do_req(1'b0, 2'd2, 1'b1, 64'd0, 64'd0, r);
    chk("lwu0", r, 64'h00000000ABCD0005);
    do_req(1'b1, 2'd3, 1'b0, 64'd24, 64'h8000000000000001, r);
    do_req(1'b0, 2'd3, 1'b0, 64'd24, 64'd0, r);
    chk("ld24", r, 64'h8000000000000001);
    do_req(1'b0, 2'd3, 1'b0, 64'd249, 64'd0, r);
    do_req(1'b1, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd7, r);
    do_req(1'b0, 2'd3, 1'b0, 64'd248, 64'd0, r);

    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_addr  = 64'd40;
    req_wdata = 64'hAB;
    seen = 0;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      if (req_ready) seen = 1;
      @(posedge clk);
      if (seen == 0) @(negedge clk);
    end
    #1 req_valid = 1'b0;
    chk("rst_test_accept", 64'(seen), 64'd1);
    @(negedge clk);
    chk("rst_test_in_rd", 64'(mem_read), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_drop_read", 64'(mem_read), 64'd0);
    chk("rst_drop_write", 64'(mem_write), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      seen += int'(resp_valid) + int'(mem_write);
    end
    chk("rst_no_resp", 64'(seen), 64'd0);
    chk("rst_ready_after", 64'(req_ready), 64'd1);
    chk("rst_dw5", mem_dw(40), 64'd12);

    for (int k = 0; k < 60; k++) begin
      rw = 1'($urandom);
      rs = 2'($urandom);
      if ($urandom_range(0, 9) == 0)
        ra = ($urandom_range(0, 1) == 0) ?
             64'($urandom_range(249, 255)) :
             {32'hFFFF_FFFF, 32'($urandom)};
      else
        ra = 64'($urandom_range(0, 248));
      do_req(rw, rs, 1'($urandom), ra,
             {32'($urandom), 32'($urandom)}, r);
    end

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== rmem[i]) bad++;
    chk("mem_final", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory initiator between the core's execute stage and the 64-bit byte-addressed data memory.
- Accepts one load or store per request handshake, sized byte, half, word or double.
- The memory only performs full 8-byte accesses (little-endian, combinational read, write on posedge), so this block does three things:
  - extracts and sign/zero-extends load data;
  - performs read-modify-write for sub-doubleword stores;
  - flags out-of-range addresses.

Parameters:
- ADDR_LIMIT, 256: memory size in bytes; the highest legal access base is ADDR_LIMIT-8.
- XLEN, 64: data and address width.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; the low 8/16/32/64 bits are used per req_size
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid; address out of range
- mem_addr  out  XLEN  to memory Mem_Addr
- mem_wdata  out  XLEN  to memory Write_Data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  XLEN  from memory Read_Data

Behaviour:
- Reset (asynchronous, reset_n low):
  - state goes to IDLE;
  - mem_read, mem_write, resp_valid and resp_fault are 0;
  - mem_addr, mem_wdata and resp_rdata are 0;
  - req_ready is 1 once reset_n is high.
- States: IDLE, RD, WR, RESP. All memory strobes are driven directly from the registered state, so they are glitch-free.
- IDLE:
  - req_ready=1. On a rising edge with req_valid=1, latch write, size, unsigned, addr and wdata.
  - Fault if the unsigned 64-bit addr > ADDR_LIMIT-8 (compare at full width, no truncation); go to RESP with fault=1.
  - Otherwise: a load goes to RD; a store with size=3 goes to WR; a store with size<3 goes to RD.
- RD (exactly one cycle):
  - mem_read=1, mem_addr=latched addr.
  - At the closing edge, capture mem_rdata.
  - Load: extract the low 8/16/32/64 bits, extend per unsigned/size (size=3 ignores unsigned), go to RESP.
  - Store: build merged = captured data with the low 8/16/32 bits replaced by wdata's low bits, upper bytes preserved; go to WR.
- WR (exactly one cycle):
  - mem_write=1, mem_addr=latched addr.
  - mem_wdata = merged data (size<3) or wdata (size=3).
  - mem_read=0. Go to RESP.
- RESP (one cycle):
  - resp_valid=1, req_ready=0; resp_fault as computed. Go to IDLE.
  - resp_rdata and resp_fault hold their values until the next RESP.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles;
  - sd: 2 cycles;
  - sb/sh/sw: 3 cycles;
  - fault: 1 cycle.
- Throughput: a new request is accepted on the edge leaving RESP+IDLE, giving a minimum 1 idle cycle between requests.
- Fault path: never asserts mem_read or mem_write.
- Address arithmetic: no wrap-around.
- Back-to-back store then load to the same address returns the new data, because WR completes before the next RD.
- Reset mid-operation: if reset_n is asserted during RD or WR, strobes drop immediately, no response is issued, and the request is lost. A write is performed only if WR reaches its rising edge with reset_n high.
- req_valid while not in IDLE is ignored; the core must hold the request until req_ready.

Decomposition:
- Shared package lsu_pkg:
  - size codes SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3;
  - state enum (IDLE, RD, WR, RESP);
  - ADDR_LIMIT default.
- One sub-module, lsu_align, purely combinational. Given raw doubleword, size, unsigned and wdata, it produces:
  - the extended load value;
  - the merged store doubleword.
- Top level is the FSM and registers only.

Test Plan:
- Memory initialised as dword0=5, dword1=10, dword2=1. ld addr 8 -> resp_rdata=0x000000000000000A, resp_fault=0, 2 cycles after accept; mem_read high exactly 1 cycle.
- sb addr 16 wdata 0xFF -> RD then WR; memory dword2=0x00000000000000FF, bytes 17..23 unchanged. Then lb addr 16 -> 0xFFFFFFFFFFFFFFFF; lbu addr 16 -> 0x00000000000000FF.
- sh addr 2 wdata 0x1234ABCD -> dword0=0x00000000ABCD0005; lw addr 0 -> 0xFFFFFFFFABCD0005; lwu addr 0 -> 0x00000000ABCD0005.
- sd addr 24 wdata 0x8000000000000001 -> mem_write 1 cycle, no mem_read, resp 2 cycles after accept; ld addr 24 returns same.
- ld addr 249 and sd addr 0xFFFFFFFFFFFFFFF8 -> resp_fault=1, resp_rdata=0 one cycle after accept; mem_read and mem_write never asserted.
- sb addr 40 accepted, reset_n pulsed low during RD -> strobes drop immediately, no resp_valid, dword5 stays 12, req_ready=1 after release.
